// File: rtl/shift_right_sequencer.sv
// Sequences a 1-bit right-shift stage to perform an N-position shift of an operand.
// Supports logical, arithmetic and rotate fill; reports last bit out and a sticky OR.
module shift_right_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic [AMT_W-1:0] amount,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             cout,
    output logic             sticky
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_shreg;
    logic [AMT_W-1:0]   r_cnt;
    logic [1:0]         r_mode;
    logic               r_cout;
    logic               r_sticky;
    logic               w_accept;
    logic               w_fill;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_next = (amount == '0) ? S_DONE : S_SHIFT;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (r_cnt == AMT_W'(1)) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Mode 2'b11 falls through to logical fill.
    always_comb begin
        w_fill = 1'b0;
        case (r_mode)
            2'b01:   w_fill = r_shreg[WIDTH-1];
            2'b10:   w_fill = r_shreg[0];
            default: w_fill = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg  <= '0;
            r_cnt    <= '0;
            r_mode   <= 2'b00;
            r_cout   <= 1'b0;
            r_sticky <= 1'b0;
        end else if (w_accept) begin
            r_shreg  <= din;
            r_cnt    <= amount;
            r_mode   <= mode;
            r_cout   <= 1'b0;
            r_sticky <= 1'b0;
        end else if (r_state == S_SHIFT) begin
            r_shreg  <= {w_fill, r_shreg[WIDTH-1:1]};
            r_cout   <= r_shreg[0];
            r_sticky <= r_sticky | r_shreg[0];
            r_cnt    <= r_cnt - AMT_W'(1);
        end
    end

    assign busy   = (r_state == S_SHIFT);
    assign done   = (r_state == S_DONE);
    assign dout   = r_shreg;
    assign cout   = r_cout;
    assign sticky = r_sticky;

endmodule

// File: tb/tb_shift_right_sequencer.sv
// Bench for shift_right_sequencer: directed vector table, multi-cycle corner sequences,
// and random commands checked against a bit-index reference model.
module tb_shift_right_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] din;
    logic [3:0] amount;
    logic [1:0] mode;
    logic       busy;
    logic       done;
    logic [7:0] dout;
    logic       cout;
    logic       sticky;

    int n_checks = 0;
    int n_pass   = 0;

    shift_right_sequencer #(.WIDTH(8), .AMT_W(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .din    (din),
        .amount (amount),
        .mode   (mode),
        .busy   (busy),
        .done   (done),
        .dout   (dout),
        .cout   (cout),
        .sticky (sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [3:0] amt;
        logic [1:0] m;
        logic [7:0] exp_dout;
        logic       exp_cout;
        logic       exp_sticky;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Bit k of the operand as seen by an unbounded right shift: beyond the top
    // the stream continues with zeros, the sign, or wraps around.
    function automatic logic ext_bit(input logic [7:0] d, input logic [1:0] m, input int k);
        if (k < 8) return d[k];
        if (m == 2'b01) return d[7];
        if (m == 2'b10) return d[k % 8];
        return 1'b0;
    endfunction

    task automatic model(input logic [7:0] d, input logic [3:0] a, input logic [1:0] m,
                         output logic [7:0] r, output logic c, output logic s);
        int n;
        n = int'(a);
        for (int i = 0; i < 8; i++) r[i] = ext_bit(d, m, i + n);
        c = (n == 0) ? 1'b0 : ext_bit(d, m, n - 1);
        s = 1'b0;
        for (int k = 0; k < n; k++) s = s | ext_bit(d, m, k);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] d, input logic [3:0] a, input logic [1:0] m);
        din    = d;
        amount = a;
        mode   = m;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Called #1 after some edge; 'already' counts edges since the accept edge, including it.
    task automatic wait_done(input string name, input int n, input int already,
                             input logic [7:0] ed, input logic ec, input logic es);
        int edges;
        int busy_cnt;
        edges    = already;
        busy_cnt = 0;
        while (!done && edges < 40) begin
            if (!busy) begin
                check({name, "_busy_gap"}, 32'(busy), 32'd1);
            end
            busy_cnt++;
            tick();
            edges++;
        end
        check({name, "_latency"}, 32'(edges), 32'(n + 1));
        check({name, "_busycnt"}, 32'(busy_cnt), 32'(n - (already - 1)));
        check({name, "_busy_with_done"}, 32'(busy), 32'd0);
        check({name, "_dout"}, 32'(dout), 32'(ed));
        check({name, "_cout"}, 32'(cout), 32'(ec));
        check({name, "_sticky"}, 32'(sticky), 32'(es));
    endtask

    initial begin
        logic [7:0] r;
        logic       c;
        logic       s;
        logic [7:0] d;
        logic [3:0] a;
        logic [1:0] m;

        vecs[0] = '{8'b11111101, 4'd1,  2'b00, 8'b01111110, 1'b1, 1'b1};
        vecs[1] = '{8'b10001110, 4'd3,  2'b01, 8'b11110001, 1'b1, 1'b1};
        vecs[2] = '{8'b11001101, 4'd4,  2'b10, 8'b11011100, 1'b1, 1'b1};
        vecs[3] = '{8'b10001111, 4'd12, 2'b00, 8'h00,       1'b0, 1'b1};
        vecs[4] = '{8'h80,       4'd7,  2'b01, 8'hFF,       1'b0, 1'b0};
        vecs[5] = '{8'b10110001, 4'd10, 2'b10, 8'b01101100, 1'b0, 1'b1};

        rst_n = 1'b0; start = 1'b0; din = 8'h00; amount = 4'd0; mode = 2'b00;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_cout_sticky", 32'({cout, sticky}), 32'd0);
        #2 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].d, vecs[i].amt, vecs[i].m);
            wait_done($sformatf("vec%0d", i), int'(vecs[i].amt), 1,
                      vecs[i].exp_dout, vecs[i].exp_cout, vecs[i].exp_sticky);
            tick();
            check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
            check($sformatf("vec%0d_hold", i), 32'(dout), 32'(vecs[i].exp_dout));
        end

        // Back-to-back: rotate, then amount=0 accepted while done is high.
        issue(8'b11001101, 4'd4, 2'b10);
        wait_done("b2b_rot", 4, 1, 8'b11011100, 1'b1, 1'b1);
        issue(8'h5A, 4'd0, 2'b01);
        wait_done("b2b_zero", 0, 1, 8'h5A, 1'b0, 1'b0);
        tick();
        check("b2b_idle", 32'(done), 32'd0);

        // Start with different data mid-shift must be ignored.
        issue(8'b10001111, 4'd12, 2'b00);
        repeat (3) tick();
        din = 8'hFF; amount = 4'd1; mode = 2'b01; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ignore_mid", 12, 5, 8'h00, 1'b0, 1'b1);
        tick();

        // Asynchronous reset between edges during SHIFT.
        issue(8'hF3, 4'd10, 2'b01);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_dout", 32'(dout), 32'd0);
        check("arst_cout_sticky", 32'({cout, sticky}), 32'd0);
        tick();
        #2 rst_n = 1'b1;
        #3;
        issue(8'h80, 4'd7, 2'b01);
        wait_done("post_rst", 7, 1, 8'hFF, 1'b0, 1'b0);
        tick();

        for (int t = 0; t < 40; t++) begin
            d = 8'($urandom);
            a = 4'($urandom_range(0, 15));
            m = 2'($urandom_range(0, 3));
            model(d, a, m, r, c, s);
            issue(d, a, m);
            wait_done($sformatf("rnd%0d_d%02h_a%0d_m%0d", t, d, a, m), int'(a), 1, r, c, s);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/shift_right_sequencer.md
# shift_right_sequencer

Multi-cycle controller that sequences a single-position right-shift datapath to perform an N-position shift of an 8-bit operand. It shifts one bit per clock and supports logical, arithmetic and rotate modes. It also reports the last bit shifted out and a sticky OR of all shifted-out bits. It sits between a requester (ALU control or test harness) and the 1-bit right-shift stage, accepting commands through a start/busy/done handshake.

## Interface
- WIDTH, 8, operand width in bits.
- AMT_W, 4, width of shift-amount field; amounts 0..15 accepted.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  command strobe; sampled at rising edge in IDLE or DONE.
- din  input  WIDTH  operand, captured on command accept.
- amount  input  AMT_W  number of single-bit shifts, captured on accept.
- mode  input  2  00 logical (fill 0), 01 arithmetic (fill MSB), 10 rotate (fill bit shifted out), 11 treated as logical; captured on accept.
- busy  output  1  high while state is SHIFT.
- done  output  1  one-cycle pulse, high while state is DONE.
- dout  output  WIDTH  shift result; valid when done=1 and held until the next accept.
- cout  output  1  last bit shifted out (bit 0 before the final shift); 0 if amount=0.
- sticky  output  1  OR of every bit shifted out during the operation; 0 if amount=0.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 latches din into the shift register and amount into the down-counter, and latches mode. cout and sticky are cleared.
  - amount≠0 goes to SHIFT.
  - amount=0 goes to DONE.
- SHIFT, each edge:
  - reg <= {fill, reg[WIDTH-1:1]}.
  - cout <= reg[0].
  - sticky <= sticky | reg[0].
  - count <= count-1.
  - When count reaches 0 after the shift (count was 1), go to DONE.
- Fill bit per mode: logical 0; arithmetic reg[WIDTH-1]; rotate reg[0].
- DONE, for one cycle:
  - start=1 is accepted exactly as in IDLE (back-to-back commands).
  - Otherwise go to IDLE.
- start in SHIFT is ignored. No queuing, no error flag.
- Amounts ≥ WIDTH are executed literally, one shift per cycle:
  - Logical: result 0.
  - Arithmetic: all bits equal to the sign.
  - Rotate: wraps, result equals a shift by amount mod WIDTH.
- dout is the shift register, visible continuously. Its value is only guaranteed when done=1 and afterwards until the next accept.

## Timing
- Accept edge E0. For amount N≥1, shifts occur at edges E1..EN.
- done is high in the cycle after EN; latency from the start edge to the done cycle is N+1 edges.
- For N=0, done is high in the cycle after E0.
- busy is high from after E0 until EN, and is never high together with done.
- Throughput: the next start can be accepted at edge EN+1 (in DONE). Minimum command spacing is N+1 cycles.
- Reset (rst_n=0, asynchronous, any state including mid-SHIFT) sets:
  - state IDLE, busy=0, done=0.
  - dout=0, cout=0, sticky=0, count=0.
- The first accept is possible at the first rising edge after rst_n deasserts.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Logical, din=8'b11111101, amount=1: done pulse 2 edges after start; dout=8'b01111110, cout=1, sticky=1.
- Arithmetic, din=8'b10001110, amount=3: busy high 3 cycles; dout=8'b11110001, cout=1, sticky=1.
- Rotate, din=8'b11001101, amount=4: dout=8'b11011100, cout=1, sticky=1. Back-to-back start during DONE with amount=0 gives done on the next cycle, dout=din, cout=0, sticky=0.
- Logical, din=8'b10001111, amount=12: busy 12 cycles; dout=8'h00, cout=0, sticky=1. A start pulse with different data mid-SHIFT is ignored (result unchanged).
- Reset mid-operation: assert rst_n=0 between clock edges during SHIFT. All outputs are 0 immediately, without waiting for an edge. After release, start with din=8'h80, arithmetic, amount=7 gives dout=8'hFF, cout=0, sticky=0.
